// File: rtl/fft_pkg.sv
// fft_pkg: shared sizing constants and FSM state type for the FFT result unloader.
package fft_pkg;

  localparam int N      = 9;
  localparam int W      = 16;
  localparam int POINTS = 1 << N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fft_out_fifo.sv
// fft_out_fifo: 2-entry FIFO with registered storage, combinational head and occupancy output.
module fft_out_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/fft_unloader.sv
// fft_unloader: streams a completed FFT result RAM out over valid/ready in natural bin order.
// Optional FFT_MAG_EN: out_re carries saturated |re|+|im| and out_im is forced to 0.
module fft_unloader #(
  parameter int N = fft_pkg::N,
  parameter int W = fft_pkg::W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         rd_en,
  output logic [N-1:0] rd_addr,
  input  logic [W-1:0] rd_re,
  input  logic [W-1:0] rd_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [N-1:0] out_idx,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  import fft_pkg::*;

  localparam int          FW        = 1 + N + 2 * W;
  localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};

  state_t         r_state;
  logic [N-1:0]   r_addr;
  logic [N-1:0]   r_pend_idx;
  logic           r_pend;
  logic           r_done;
  logic [1:0]     w_count;
  logic [2:0]     w_load;
  logic           w_fifo_valid;
  logic           w_pop;
  logic           w_issue;
  logic           w_last_out;
  logic [W-1:0]   w_re;
  logic [W-1:0]   w_im;
  logic [FW-1:0]  w_wdata;
  logic [FW-1:0]  w_rdata;

  // Occupancy after this cycle's pop plus the word landing this cycle must leave room for a new read.
  assign w_pop   = w_fifo_valid && out_ready;
  assign w_load  = {1'b0, w_count} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue = (r_state == READ) && (w_load < 3'd2);

  assign rd_en   = w_issue;
  assign rd_addr = r_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_pend <= w_issue;
      r_done <= w_pop && w_last_out;
      if (w_issue) begin
        r_pend_idx <= r_addr;
        r_addr     <= r_addr + 1'b1;
      end
      case (r_state)
        IDLE:    if (start) r_state <= READ;
        READ:    if (w_issue && (r_addr == LAST_ADDR)) r_state <= DRAIN;
        DRAIN:   if (w_pop && w_last_out) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FFT_MAG_EN
  logic [W:0]   w_abs_re;
  logic [W:0]   w_abs_im;
  logic [W+1:0] w_sum;

  // One extra bit keeps |most negative| representable before the saturating add.
  assign w_abs_re = rd_re[W-1] ? ((W+1)'(0) - {rd_re[W-1], rd_re}) : {1'b0, rd_re};
  assign w_abs_im = rd_im[W-1] ? ((W+1)'(0) - {rd_im[W-1], rd_im}) : {1'b0, rd_im};
  assign w_sum    = {1'b0, w_abs_re} + {1'b0, w_abs_im};
  assign w_re     = (w_sum > {3'b000, {(W-1){1'b1}}}) ? {1'b0, {(W-1){1'b1}}} : w_sum[W-1:0];
  assign w_im     = '0;
`else
  assign w_re = rd_re;
  assign w_im = rd_im;
`endif

  assign w_wdata = {(r_pend_idx == LAST_ADDR), r_pend_idx, w_re, w_im};

  fft_out_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_pend),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .o_data  (w_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign w_last_out = w_rdata[FW-1];
  assign out_valid  = w_fifo_valid;
  assign out_last   = w_last_out;
  assign out_idx    = w_rdata[2*W +: N];
  assign out_re     = w_rdata[W +: W];
  assign out_im     = w_rdata[0 +: W];
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_fft_unloader.sv
// tb_fft_unloader: randomized self-checking bench for fft_unloader against a bin-level reference model.
// Honours FFT_MAG_EN the same way as the design.
module tb_fft_unloader;

  localparam int N   = 9;
  localparam int W   = 16;
  localparam int PTS = 1 << N;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         rd_en;
  logic [N-1:0] rd_addr;
  logic [W-1:0] rd_re = '0;
  logic [W-1:0] rd_im = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic [N-1:0] out_idx;
  logic         out_last;
  logic         busy;
  logic         done;

  int checks = 0;
  int passes = 0;

  logic [W-1:0] memRe [PTS];
  logic [W-1:0] memIm [PTS];
  logic [N-1:0] rdLog [$];

  logic [W-1:0] obsRe [$];
  logic [W-1:0] obsIm [$];
  logic [N-1:0] obsIdx [$];
  logic         obsLast [$];
  int           doneCycles [$];
  int           firstValidCycle, lastHsCycle, stableViol, lastHeld, rdBase;
  logic         timedOut, cyc1RdEn, cyc2Valid;
  logic [N-1:0] cyc1RdAddr;

  fft_unloader #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_re     (rd_re),
    .rd_im     (rd_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Result RAM: one-cycle read latency, and every issued address is logged.
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      rd_re <= memRe[rd_addr];
      rd_im <= memIm[rd_addr];
      rdLog.push_back(rd_addr);
    end
  end

  function automatic logic [W-1:0] expRe(input int k);
`ifdef FFT_MAG_EN
    int a, b, s;
    a = int'($signed(memRe[k]));
    b = int'($signed(memIm[k]));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    s = a + b;
    if (s > 32767) s = 32767;
    return W'(s);
`else
    return memRe[k];
`endif
  endfunction

  function automatic logic [W-1:0] expIm(input int k);
`ifdef FFT_MAG_EN
    return '0;
`else
    return memIm[k];
`endif
  endfunction

  // Pulses start, then runs the stream with the given ready policy and records what comes out.
  task automatic applyStimulus(input int pct, input int holdLast, input int restartAt,
                               input int abortAt, input int maxCycles);
    int cyc, held;
    logic restarted, heldPrev, pLast;
    logic [W-1:0] pRe, pIm;
    logic [N-1:0] pIdx;
    obsRe.delete(); obsIm.delete(); obsIdx.delete(); obsLast.delete(); doneCycles.delete();
    firstValidCycle = -1; lastHsCycle = -1; stableViol = 0; lastHeld = 0; timedOut = 1'b0;
    rdBase = rdLog.size(); held = 0; restarted = 1'b0; heldPrev = 1'b0;
    pRe = '0; pIm = '0; pIdx = '0; pLast = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    forever begin
      out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      if (holdLast > 0 && out_valid && out_last && held < holdLast) begin
        out_ready = 1'b0;
        held++;
      end
      start = 1'b0;
      if (restartAt >= 0 && !restarted && obsRe.size() == restartAt) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      #1;
      if (cyc == 1) begin cyc1RdEn = rd_en; cyc1RdAddr = rd_addr; end
      if (cyc == 2) cyc2Valid = out_valid;
      if (heldPrev && (!out_valid || {out_re, out_im, out_idx, out_last} !== {pRe, pIm, pIdx, pLast}))
        stableViol++;
      if (out_valid && firstValidCycle < 0) firstValidCycle = cyc;
      if (out_valid && out_last && !out_ready) lastHeld++;
      if (done) doneCycles.push_back(cyc);
      if (out_valid && out_ready) begin
        obsRe.push_back(out_re); obsIm.push_back(out_im);
        obsIdx.push_back(out_idx); obsLast.push_back(out_last);
        if (out_last) lastHsCycle = cyc;
      end
      heldPrev = out_valid && !out_ready;
      pRe = out_re; pIm = out_im; pIdx = out_idx; pLast = out_last;
      if (abortAt >= 0 && obsRe.size() >= abortAt) break;
      if (doneCycles.size() > 0 && cyc >= doneCycles[0] + 3) break;
      if (cyc >= maxCycles) begin timedOut = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    checks++; if (rd_en !== 1'b0) $display("[TB] FAIL reset rd_en: got %b want 0", rd_en); else passes++;
    checks++; if (rd_addr !== '0) $display("[TB] FAIL reset rd_addr: got %0d want 0", rd_addr); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); else passes++;
    checks++; if ({out_re, out_im} !== '0) $display("[TB] FAIL reset out_data: got %h want 0", {out_re, out_im}); else passes++;
    checks++; if ({out_idx, out_last} !== '0) $display("[TB] FAIL reset out_idx/last: got %h want 0", {out_idx, out_last}); else passes++;
    checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL reset busy/done: got %b want 00", {busy, done}); else passes++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, rd_en, out_valid} !== 3'b000) $display("[TB] FAIL idle_after_reset: got %b want 000", {busy, rd_en, out_valid}); else passes++;
  endtask

  task automatic test_nominal;
    int dc, bad;
    for (int k = 0; k < PTS; k++) begin memRe[k] = W'(k); memIm[k] = W'(-k); end
    applyStimulus(100, 0, -1, -1, 2000);
    dc = (doneCycles.size() > 0) ? doneCycles[0] : -1;
    checks++; if (timedOut) $display("[TB] FAIL nominal timeout: got timeout want done"); else passes++;
    checks++; if ({cyc1RdEn, cyc1RdAddr} !== {1'b1, N'(0)}) $display("[TB] FAIL nominal cycle1 read: got en=%b addr=%0d want en=1 addr=0", cyc1RdEn, cyc1RdAddr); else passes++;
    checks++; if (cyc2Valid !== 1'b0) $display("[TB] FAIL nominal cycle2 valid: got %b want 0", cyc2Valid); else passes++;
    checks++; if (firstValidCycle != 3) $display("[TB] FAIL nominal first_valid: got %0d want 3", firstValidCycle); else passes++;
    checks++; if (lastHsCycle != PTS + 2) $display("[TB] FAIL nominal last_handshake: got %0d want %0d", lastHsCycle, PTS + 2); else passes++;
    checks++; if (dc != PTS + 3 || doneCycles.size() != 1) $display("[TB] FAIL nominal done: got cycle %0d count %0d want cycle %0d count 1", dc, doneCycles.size(), PTS + 3); else passes++;
    checks++; if (obsRe.size() != PTS) $display("[TB] FAIL nominal bin_count: got %0d want %0d", obsRe.size(), PTS); else passes++;
    for (int k = 0; k < obsRe.size() && k < PTS; k++) begin
      checks++;
      if ({obsIdx[k], obsLast[k], obsRe[k], obsIm[k]} !== {N'(k), (k == PTS - 1), expRe(k), expIm(k)})
        $display("[TB] FAIL nominal bin %0d: got idx=%0d last=%b re=%h im=%h want re=%h im=%h", k, obsIdx[k], obsLast[k], obsRe[k], obsIm[k], expRe(k), expIm(k));
      else passes++;
    end
    bad = 0;
    for (int k = 0; k < PTS && rdBase + k < rdLog.size(); k++) if (rdLog[rdBase + k] != N'(k)) bad++;
    checks++; if (rdLog.size() - rdBase != PTS || bad != 0) $display("[TB] FAIL nominal read_order: got %0d reads %0d misordered want %0d reads 0 misordered", rdLog.size() - rdBase, bad, PTS); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL nominal busy_after: got %b want 0", busy); else passes++;
  endtask

  task automatic test_backpressure;
    int bad;
    for (int k = 0; k < PTS; k++) begin memRe[k] = W'($urandom); memIm[k] = W'($urandom); end
    applyStimulus(30, 0, -1, -1, 4000);
    checks++; if (timedOut) $display("[TB] FAIL backpressure timeout: got timeout want done"); else passes++;
    checks++; if (obsRe.size() != PTS) $display("[TB] FAIL backpressure bin_count: got %0d want %0d", obsRe.size(), PTS); else passes++;
    checks++; if (stableViol != 0) $display("[TB] FAIL backpressure stability: got %0d changes want 0", stableViol); else passes++;
    checks++; if (doneCycles.size() != 1) $display("[TB] FAIL backpressure done_count: got %0d want 1", doneCycles.size()); else passes++;
    for (int k = 0; k < obsRe.size() && k < PTS; k++) begin
      checks++;
      if ({obsIdx[k], obsLast[k], obsRe[k], obsIm[k]} !== {N'(k), (k == PTS - 1), expRe(k), expIm(k)})
        $display("[TB] FAIL backpressure bin %0d: got idx=%0d last=%b re=%h im=%h want re=%h im=%h", k, obsIdx[k], obsLast[k], obsRe[k], obsIm[k], expRe(k), expIm(k));
      else passes++;
    end
    bad = 0;
    for (int k = 0; k < PTS && rdBase + k < rdLog.size(); k++) if (rdLog[rdBase + k] != N'(k)) bad++;
    checks++; if (rdLog.size() - rdBase != PTS || bad != 0) $display("[TB] FAIL backpressure read_order: got %0d reads %0d misordered want %0d reads 0 misordered", rdLog.size() - rdBase, bad, PTS); else passes++;
  endtask

  task automatic test_start_while_busy;
    for (int k = 0; k < PTS; k++) begin memRe[k] = W'($urandom); memIm[k] = W'($urandom); end
    applyStimulus(100, 0, 100, -1, 2000);
    checks++; if (obsRe.size() != PTS) $display("[TB] FAIL restart bin_count: got %0d want %0d", obsRe.size(), PTS); else passes++;
    checks++; if (doneCycles.size() != 1) $display("[TB] FAIL restart done_count: got %0d want 1", doneCycles.size()); else passes++;
    checks++; if (rdLog.size() - rdBase != PTS) $display("[TB] FAIL restart read_count: got %0d want %0d", rdLog.size() - rdBase, PTS); else passes++;
    for (int k = 0; k < obsRe.size() && k < PTS; k++) begin
      checks++;
      if ({obsIdx[k], obsRe[k], obsIm[k]} !== {N'(k), expRe(k), expIm(k)})
        $display("[TB] FAIL restart bin %0d: got idx=%0d re=%h im=%h want re=%h im=%h", k, obsIdx[k], obsRe[k], obsIm[k], expRe(k), expIm(k));
      else passes++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if ({busy, out_valid} !== 2'b00) $display("[TB] FAIL restart idle_after: got %b want 00", {busy, out_valid}); else passes++;
  endtask

  task automatic test_reset_mid_frame;
    for (int k = 0; k < PTS; k++) begin memRe[k] = W'(k + 1); memIm[k] = W'($urandom); end
    applyStimulus(100, 0, -1, 200, 2000);
    reset_n = 1'b0;
    #2;
    checks++; if ({rd_en, rd_addr, busy, done} !== '0) $display("[TB] FAIL midreset ctrl: got %h want 0", {rd_en, rd_addr, busy, done}); else passes++;
    checks++; if ({out_valid, out_last, out_idx} !== '0) $display("[TB] FAIL midreset stream: got %h want 0", {out_valid, out_last, out_idx}); else passes++;
    checks++; if ({out_re, out_im} !== '0) $display("[TB] FAIL midreset data: got %h want 0", {out_re, out_im}); else passes++;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if ({busy, rd_en, out_valid} !== 3'b000) $display("[TB] FAIL midreset no_autostart: got %b want 000", {busy, rd_en, out_valid}); else passes++;
    applyStimulus(100, 0, -1, -1, 2000);
    checks++; if (obsRe.size() != PTS) $display("[TB] FAIL midreset bin_count: got %0d want %0d", obsRe.size(), PTS); else passes++;
    checks++; if (firstValidCycle != 3) $display("[TB] FAIL midreset first_valid: got %0d want 3", firstValidCycle); else passes++;
    for (int k = 0; k < obsRe.size() && k < PTS; k++) begin
      checks++;
      if ({obsIdx[k], obsLast[k], obsRe[k], obsIm[k]} !== {N'(k), (k == PTS - 1), expRe(k), expIm(k)})
        $display("[TB] FAIL midreset bin %0d: got idx=%0d re=%h im=%h want re=%h im=%h", k, obsIdx[k], obsRe[k], obsIm[k], expRe(k), expIm(k));
      else passes++;
    end
  endtask

  task automatic test_saturation;
    logic [W-1:0] wantRe0, wantIm0;
    for (int k = 0; k < PTS; k++) begin memRe[k] = W'($urandom); memIm[k] = W'($urandom); end
    memRe[0] = 16'h8000; memIm[0] = 16'h7FFF;
    memRe[1] = 16'h7FFF; memIm[1] = 16'h7FFF;
    memRe[2] = 16'h8000; memIm[2] = 16'h8000;
    memRe[3] = 16'hFFFD; memIm[3] = 16'h0004;
`ifdef FFT_MAG_EN
    wantRe0 = 16'h7FFF; wantIm0 = 16'h0000;
`else
    wantRe0 = 16'h8000; wantIm0 = 16'h7FFF;
`endif
    applyStimulus(100, 0, -1, -1, 2000);
    checks++; if (obsRe.size() != PTS) $display("[TB] FAIL saturation bin_count: got %0d want %0d", obsRe.size(), PTS); else passes++;
    if (obsRe.size() > 0) begin
      checks++; if ({obsRe[0], obsIm[0]} !== {wantRe0, wantIm0}) $display("[TB] FAIL saturation bin0: got re=%h im=%h want re=%h im=%h", obsRe[0], obsIm[0], wantRe0, wantIm0); else passes++;
    end
    for (int k = 0; k < obsRe.size() && k < PTS; k++) begin
      checks++;
      if ({obsRe[k], obsIm[k]} !== {expRe(k), expIm(k)})
        $display("[TB] FAIL saturation bin %0d: got re=%h im=%h want re=%h im=%h", k, obsRe[k], obsIm[k], expRe(k), expIm(k));
      else passes++;
    end
  endtask

  task automatic test_last_timing;
    int dc;
    for (int k = 0; k < PTS; k++) begin memRe[k] = W'($urandom); memIm[k] = W'($urandom); end
    applyStimulus(100, 5, -1, -1, 2000);
    dc = (doneCycles.size() > 0) ? doneCycles[0] : -1;
    checks++; if (lastHeld != 5) $display("[TB] FAIL last_timing held: got %0d cycles want 5", lastHeld); else passes++;
    checks++; if (lastHsCycle != PTS + 7) $display("[TB] FAIL last_timing handshake: got %0d want %0d", lastHsCycle, PTS + 7); else passes++;
    checks++; if (dc != PTS + 8 || doneCycles.size() != 1) $display("[TB] FAIL last_timing done: got cycle %0d count %0d want cycle %0d count 1", dc, doneCycles.size(), PTS + 8); else passes++;
    checks++; if (stableViol != 0) $display("[TB] FAIL last_timing stability: got %0d changes want 0", stableViol); else passes++;
    if (obsRe.size() == PTS) begin
      checks++; if ({obsIdx[PTS-1], obsLast[PTS-1], obsRe[PTS-1]} !== {N'(PTS - 1), 1'b1, expRe(PTS - 1)}) $display("[TB] FAIL last_timing last_bin: got idx=%0d last=%b re=%h want idx=%0d last=1 re=%h", obsIdx[PTS-1], obsLast[PTS-1], obsRe[PTS-1], PTS - 1, expRe(PTS - 1)); else passes++;
    end else begin
      checks++; $display("[TB] FAIL last_timing bin_count: got %0d want %0d", obsRe.size(), PTS);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_frame;
    test_saturation;
    test_last_timing;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fft_unloader.md
FFT_UNLOADER -- requirements
Module: fft_unloader

Interface
REQ-001 SHALL have parameter N, default 9, log2 of FFT length (512 points).
REQ-002 SHALL have parameter W, default 16, real/imag sample width, two's complement.
REQ-003 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse: FFT result RAM complete.
REQ-006 SHALL have port rd_en  output  1  result-RAM read strobe.
REQ-007 SHALL have port rd_addr  output  N  result-RAM read address.
REQ-008 SHALL have ports rd_re, rd_im  input  W each  RAM data; valid exactly 1 cycle after rd_en.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: valid/ready stream handshake.
REQ-010 SHALL have ports out_re, out_im  output  W each  bin value.
REQ-011 SHALL have ports out_idx output N (bin index) and out_last output 1 (bin 2^N-1).
REQ-012 SHALL have ports busy output 1 and done output 1 (one-cycle pulse).

Function
REQ-013 SHALL use FSM states IDLE, READ, DRAIN.
- IDLE -> READ on start.
- READ -> DRAIN after address 2^N-1 is issued.
- DRAIN -> IDLE on the handshake of out_last.
REQ-014 SHALL read addresses 0..2^N-1 in natural order, each exactly once. Butterfly output is already natural-ordered, so no reordering is done here.
REQ-015 SHALL transfer a bin only on a cycle where out_valid && out_ready.
REQ-016 SHALL hold out_re/out_im/out_idx/out_last stable while out_valid && !out_ready.
REQ-017 SHALL buffer in a 2-entry FIFO.
- rd_en asserts only when (FIFO occupancy + reads in flight) < 2.
- No data is dropped under any out_ready pattern.
REQ-018 SHALL have latency: start at edge 0 -> rd_en/rd_addr=0 during cycle 1 -> out_valid during cycle 3.
REQ-019 SHALL sustain 1 bin/cycle with no bubbles while out_ready is held high. Last handshake occurs in cycle 2^N+2.
REQ-020 SHALL assert out_last only together with out_idx = 2^N-1.
REQ-021 SHALL pulse done for one cycle, in the cycle after the out_last handshake.
REQ-022 SHALL ignore start while busy; the frame is neither restarted nor corrupted.
REQ-023 SHALL assert busy in READ and DRAIN only.
REQ-024 SHALL have rd_addr wrap to 0 at frame end. No address beyond 2^N-1 is ever issued.

Reset
REQ-025 SHALL on reset_n low, immediately and asynchronously:
- set state to IDLE and flush the FIFO;
- force rd_en, rd_addr, out_valid, out_re, out_im, out_idx, out_last, busy, done to 0.
REQ-026 SHALL, when reset_n is asserted mid-frame, abandon the frame; the first frame after release requires a new start.

Configuration
REQ-027 SHALL, with FFT_MAG_EN defined:
- out_re = min(|rd_re| + |rd_im|, 2^(W-1)-1), saturated;
- out_im = 0;
- latency per REQ-018 is unchanged (computed before the FIFO write).
REQ-028 SHALL, without FFT_MAG_EN, pass rd_re/rd_im through unmodified.

Structure
REQ-029 SHALL take N, W, POINTS = 2^N and the state enum from shared package fft_pkg.
REQ-030 SHALL implement the 2-entry FIFO as sub-module fft_out_fifo (parameterised width, occupancy output).

Verification
REQ-031 SHALL cover nominal frame:
- stimulus: RAM word k = {re=k, im=-k}, out_ready=1, start pulse;
- response: 512 bins idx 0..511, first out_valid in cycle 3, done in cycle 515.
REQ-032 SHALL cover backpressure:
- stimulus: out_ready random 30% duty;
- response: all 512 bins in order, none duplicated or lost, outputs stable while stalled.
REQ-033 SHALL cover start while busy:
- stimulus: second start pulse at bin 100;
- response: single frame of 512 bins, one done pulse.
REQ-034 SHALL cover reset mid-frame:
- stimulus: reset_n low at bin 200, then new start;
- response: all outputs 0 during reset, fresh frame from idx 0.
REQ-035 SHALL cover FFT_MAG_EN saturation:
- stimulus: re=-32768, im=32767;
- response: out_re=32767, out_im=0.
REQ-036 SHALL cover out_last timing:
- stimulus: out_ready held low when idx 511 is presented, released 5 cycles later;
- response: out_last held 5 cycles, done in the cycle after release.
